mire_gen: RTL and testbench

Parametrised successor to the fixed-grid test-pattern writer. It is a Wishbone master that fills a HDISP x VDISP 32-bit framebuffer in SDRAM with one of four selectable test patterns. It writes frame after frame while enabled, and releases the bus after every BURST_LEN accesses so other masters (the display reader) can arbitrate. It sits beside the framebuffer reader on the SDRAM Wishbone arbiter.

---
 rtl/mire_gen_pkg.sv | 30 +++
 rtl/wshb_if.sv | 17 +
 rtl/mire_gen_pattern.sv | 125 ++++++++++++
 rtl/mire_gen.sv | 136 +++++++++++++
 tb/tb_mire_gen.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mire_gen_pkg.sv
// Shared types, colour constants and pixel packing for the mire_gen test-pattern writer.
package mire_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GRID    = 2'd0,
    BARS    = 2'd1,
    RAMP    = 2'd2,
    CHECKER = 2'd3
  } mode_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  function automatic logic [31:0] rgb(input logic [23:0] col);
    return {8'h00, col};
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle used between the pattern writer and the SDRAM arbiter.
interface wshb_if;
  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        ack;

  modport master (
    input  clk, rst, ack,
    output cyc, stb, we, sel, adr, dat_ms
  );
endinterface

// File: rtl/mire_gen_pattern.sv
// Pixel colour generator: tracks the pattern column px and the colour-bar position.
// With MIRE_GEN_SCROLL_EN defined, px starts each frame at a scroll offset that moves by one per frame.
module mire_gen_pattern
  import mire_gen_pkg::*;
#(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter int unsigned GRID_LOG2 = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       frame_start_i,
  input  logic                       advance_i,
  input  mode_e                      mode_i,
  input  logic [$clog2(VDISP)-1:0]   y_i,
  output logic [23:0]                rgb_o
);

  localparam int unsigned XW = $clog2(HDISP);
  localparam int unsigned BW = HDISP / 8;
  localparam logic [31:0] GMASK = (32'd1 << GRID_LOG2) - 32'd1;

  typedef struct packed {
    logic [XW-1:0] px;
    logic [2:0]    bar;
    logic [XW-1:0] sub;
  } pos_t;

  // Step one column right; the bar index moves on every BW columns and sticks at 7 for the remainder.
  function automatic pos_t pos_inc(input pos_t p);
    pos_t n;
    n = p;
    if (p.px == XW'(HDISP - 1)) begin
      n.px  = '0;
      n.bar = 3'd0;
      n.sub = '0;
    end else begin
      n.px = p.px + 1'b1;
      if ((p.bar != 3'd7) && (p.sub == XW'(BW - 1))) begin
        n.bar = p.bar + 3'd1;
        n.sub = '0;
      end else begin
        n.sub = p.sub + 1'b1;
      end
    end
    return n;
  endfunction

  pos_t pos_q;

`ifdef MIRE_GEN_SCROLL_EN
  pos_t scroll_q;

  // Column tracker; a frame end both advances the scroll offset and preloads the next frame from it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q    <= '0;
      scroll_q <= '0;
    end else if (frame_start_i && advance_i) begin
      scroll_q <= pos_inc(scroll_q);
      pos_q    <= pos_inc(scroll_q);
    end else if (frame_start_i) begin
      pos_q <= scroll_q;
    end else if (advance_i) begin
      pos_q <= pos_inc(pos_q);
    end else begin
      pos_q <= pos_q;
    end
  end
`else
  // Column tracker restarting at column 0 on every frame start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q <= '0;
    end else if (frame_start_i) begin
      pos_q <= '0;
    end else if (advance_i) begin
      pos_q <= pos_inc(pos_q);
    end else begin
      pos_q <= pos_q;
    end
  end
`endif

  logic [31:0] px_ext_s;
  logic [31:0] y_ext_s;

  // Colour of the current pixel from the latched mode, pattern column and line.
  always_comb begin
    rgb_o    = COL_BLACK;
    px_ext_s = 32'(pos_q.px);
    y_ext_s  = 32'(y_i);
    case (mode_i)
      GRID: begin
        if (((px_ext_s & GMASK) == 32'd0) || ((y_ext_s & GMASK) == 32'd0)) begin
          rgb_o = COL_WHITE;
        end else begin
          rgb_o = COL_BLACK;
        end
      end
      BARS: begin
        case (pos_q.bar)
          3'd0:    rgb_o = COL_WHITE;
          3'd1:    rgb_o = COL_YELLOW;
          3'd2:    rgb_o = COL_CYAN;
          3'd3:    rgb_o = COL_GREEN;
          3'd4:    rgb_o = COL_MAGENTA;
          3'd5:    rgb_o = COL_RED;
          3'd6:    rgb_o = COL_BLUE;
          default: rgb_o = COL_BLACK;
        endcase
      end
      RAMP: rgb_o = {px_ext_s[7:0], px_ext_s[7:0], px_ext_s[7:0]};
      CHECKER: begin
        if (px_ext_s[GRID_LOG2] ^ y_ext_s[GRID_LOG2]) begin
          rgb_o = COL_WHITE;
        end else begin
          rgb_o = COL_BLACK;
        end
      end
      default: rgb_o = COL_BLACK;
    endcase
  end

endmodule

// File: rtl/mire_gen.sv
// Wishbone master filling an HDISP x VDISP framebuffer with test patterns, releasing the bus every BURST_LEN beats.
// Optional horizontal scrolling is built when MIRE_GEN_SCROLL_EN is defined.
module mire_gen
  import mire_gen_pkg::*;
#(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int unsigned BURST_LEN = 64,
  parameter int unsigned GRID_LOG2 = 4
) (
  wshb_if.master      wshb_ifm,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned XW  = $clog2(HDISP);
  localparam int unsigned YW  = $clog2(VDISP);
  localparam int unsigned BLW = $clog2(BURST_LEN);

  state_e         state_q;
  logic           cyc_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic [31:0]    adr_q;
  logic [BLW-1:0] beat_q;
  mode_e          mode_q;
  logic           frame_done_q;
  logic [15:0]    frame_cnt_q;

  logic        ack_s;
  logic        last_s;
  logic        frame_start_s;
  logic [23:0] pix_s;

  assign ack_s         = (state_q == BURST) && wshb_ifm.ack;
  assign last_s        = ack_s && (x_q == XW'(HDISP - 1)) && (y_q == YW'(VDISP - 1));
  assign frame_start_s = ((state_q == IDLE) && enable) || last_s;

  // Bus FSM with pixel position, address, beat and frame bookkeeping.
  always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
    if (wshb_ifm.rst) begin
      state_q      <= IDLE;
      cyc_q        <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      adr_q        <= BASE_ADR;
      beat_q       <= '0;
      mode_q       <= GRID;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            mode_q  <= mode_e'(mode);
            x_q     <= '0;
            y_q     <= '0;
            adr_q   <= BASE_ADR;
            beat_q  <= '0;
            cyc_q   <= 1'b1;
            state_q <= BURST;
          end else begin
            cyc_q <= 1'b0;
          end
        end
        BURST: begin
          if (last_s) begin
            // Frame end wins over burst end; the next frame starts on a fresh burst.
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 16'd1;
            x_q          <= '0;
            y_q          <= '0;
            adr_q        <= BASE_ADR;
            beat_q       <= '0;
            mode_q       <= mode_e'(mode);
            cyc_q        <= 1'b0;
            state_q      <= enable ? GAP : IDLE;
          end else if (ack_s) begin
            if (x_q == XW'(HDISP - 1)) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
            adr_q <= adr_q + 32'd4;
            if (beat_q == BLW'(BURST_LEN - 1)) begin
              beat_q  <= '0;
              cyc_q   <= 1'b0;
              state_q <= GAP;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end else begin
            cyc_q <= 1'b1;
          end
        end
        GAP: begin
          cyc_q   <= 1'b1;
          state_q <= BURST;
        end
        default: begin
          cyc_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  mire_gen_pattern #(
    .HDISP     (HDISP),
    .VDISP     (VDISP),
    .GRID_LOG2 (GRID_LOG2)
  ) u_pattern (
    .clk_i         (wshb_ifm.clk),
    .rst_i         (wshb_ifm.rst),
    .frame_start_i (frame_start_s),
    .advance_i     (ack_s),
    .mode_i        (mode_q),
    .y_i           (y_q),
    .rgb_o         (pix_s)
  );

  assign wshb_ifm.cyc    = cyc_q;
  assign wshb_ifm.stb    = cyc_q;
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = 4'b1111;
  assign wshb_ifm.adr    = adr_q;
  assign wshb_ifm.dat_ms = rgb(pix_s);
  assign frame_done      = frame_done_q;
  assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_mire_gen.sv
// Self-checking bench for mire_gen: a pixel-index model checked every cycle plus literal pins.
module tb_mire_gen;

  localparam int H     = 16;
  localparam int V     = 4;
  localparam int BL    = 8;
  localparam int G     = 4;
  localparam int NPIX  = H * V;
  localparam int BOUND = 3000;

  wshb_if bus ();
  logic        enable;
  logic [1:0]  mode;
  logic        frame_done;
  logic [15:0] frame_cnt;

  mire_gen #(
    .HDISP     (H),
    .VDISP     (V),
    .BASE_ADR  (32'h0000_0100),
    .BURST_LEN (BL),
    .GRID_LOG2 (2)
  ) dut (
    .wshb_ifm   (bus.master),
    .enable     (enable),
    .mode       (mode),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  int n_pass  = 0;
  int n_check = 0;
  int ack_delay = 0;
  int wcnt = 0;

  // model: phase 0 idle, 1 bus owned, 2 released for one cycle
  int   m_phase  = 0;
  int   m_pix    = 0;
  int   m_beats  = 0;
  int   m_mode   = 0;
  int   m_frames = 0;
  int   m_scr    = 0;
  logic m_done   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_pix(input int p, input int md, input int scr);
    int x, y, xs, bar;
    logic [23:0] c;
    logic [7:0]  r8;
    x  = p % H;
    y  = p / H;
    xs = (x + scr) % H;
    c  = 24'h000000;
    case (md)
      0: c = ((xs % G == 0) || (y % G == 0)) ? 24'hFFFFFF : 24'h000000;
      1: begin
        bar = xs / (H / 8);
        if (bar > 7) bar = 7;
        case (bar)
          0: c = 24'hFFFFFF;
          1: c = 24'hFFFF00;
          2: c = 24'h00FFFF;
          3: c = 24'h00FF00;
          4: c = 24'hFF00FF;
          5: c = 24'hFF0000;
          6: c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      2: begin
        r8 = 8'(xs);
        c  = {r8, r8, r8};
      end
      3: c = (((xs / G) % 2) != ((y / G) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: c = 24'h000000;
    endcase
    return {8'h00, c};
  endfunction

  initial begin
    bus.clk = 1'b0;
    forever #5 bus.clk = ~bus.clk;
  end

  // Slave: ack every cycle, or after ack_delay wait cycles per access.
  always @(negedge bus.clk) begin
    if (ack_delay == 0) begin
      bus.ack = 1'b1;
    end else if (bus.stb === 1'b1 && bus.ack !== 1'b1) begin
      if (wcnt == ack_delay) begin
        bus.ack = 1'b1;
        wcnt = 0;
      end else begin
        bus.ack = 1'b0;
        wcnt = wcnt + 1;
      end
    end else begin
      bus.ack = 1'b0;
    end
  end

  // Reference model in terms of pixel index, beats since release and frames.
  always @(posedge bus.clk or posedge bus.rst) begin
    if (bus.rst) begin
      m_phase <= 0; m_pix <= 0; m_beats <= 0; m_mode <= 0;
      m_frames <= 0; m_scr <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (m_phase)
        0: if (enable) begin
          m_phase <= 1; m_pix <= 0; m_beats <= 0; m_mode <= int'(mode);
        end
        2: m_phase <= 1;
        default: if (bus.ack) begin
          if (m_pix == NPIX - 1) begin
            m_pix    <= 0;
            m_beats  <= 0;
            m_frames <= (m_frames + 1) % 65536;
            m_done   <= 1'b1;
            m_mode   <= int'(mode);
            m_phase  <= enable ? 2 : 0;
`ifdef MIRE_GEN_SCROLL_EN
            m_scr    <= (m_scr + 1) % H;
`endif
          end else begin
            m_pix <= m_pix + 1;
            if (m_beats == BL - 1) begin
              m_beats <= 0;
              m_phase <= 2;
            end else begin
              m_beats <= m_beats + 1;
            end
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge bus.clk) begin
    if (bus.rst === 1'b0) begin
      check("cyc", {31'd0, bus.cyc}, (m_phase == 1) ? 32'd1 : 32'd0);
      check("stb", {31'd0, bus.stb}, (m_phase == 1) ? 32'd1 : 32'd0);
      check("frame_done", {31'd0, frame_done}, {31'd0, m_done});
      check("frame_cnt", {16'd0, frame_cnt}, 32'(m_frames));
      if (m_phase == 1) begin
        check("adr", bus.adr, 32'h100 + 32'(4 * m_pix));
        check("dat", bus.dat_ms, exp_pix(m_pix, m_mode, m_scr));
        check("we_sel", {27'd0, bus.we, bus.sel}, 32'h1F);
      end
    end
  end

  task automatic wait_pix(input int target);
    int n;
    n = 0;
    do begin
      @(negedge bus.clk);
      n++;
    end while (!(m_phase == 1 && m_pix == target) && n < BOUND);
    check("wait_pix_timeout", (n < BOUND) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_frames(input int k);
    int n;
    n = 0;
    do begin
      @(negedge bus.clk);
      n++;
    end while (m_frames != k && n < BOUND);
    check("wait_frame_timeout", (n < BOUND) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    bus.rst = 1'b1;
    enable  = 1'b0;
    mode    = 2'd0;
    repeat (2) @(negedge bus.clk);
    check("rst_cyc", {31'd0, bus.cyc}, 32'd0);
    check("rst_adr", bus.adr, 32'h100);
    check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    bus.rst = 1'b0;
    enable  = 1'b1;

    // grid, ack every cycle
    wait_pix(0);
    check("pin_first_adr", bus.adr, 32'h100);
    check("pin_first_dat", bus.dat_ms, 32'h00FFFFFF);
    wait_pix(17);
    check("pin_x1y1_adr", bus.adr, 32'h144);
    check("pin_x1y1_dat", bus.dat_ms, 32'h00000000);

    // slow slave for the rest of frame 1
    ack_delay = 3;
    wait_frames(1);
    check("pin_cnt1", {16'd0, frame_cnt}, 32'd1);
    ack_delay = 0;
    // mode change during frame 2 only affects frame 3
    mode = 2'd1;
    wait_frames(2);
    wait_pix(2);
    check("pin_bar_x2", bus.dat_ms, 32'h00FFFF00);
    wait_pix(10);
    check("pin_bar_x10", bus.dat_ms, 32'h00FF0000);
    wait_pix(14);
    check("pin_bar_x14", bus.dat_ms, 32'h00000000);
    wait_pix(15);
    check("pin_bar_x15", bus.dat_ms, 32'h00000000);
    wait_pix(30);
    mode = 2'd2;
    wait_frames(3);
    wait_pix(5);
    check("pin_ramp_x5", bus.dat_ms, 32'h00050505);

    // enable dropped mid-frame: frame completes, then idle
    wait_pix(20);
    enable = 1'b0;
    wait_frames(4);
    repeat (3) @(negedge bus.clk);
    check("pin_idle_cyc", {31'd0, bus.cyc}, 32'd0);
    check("pin_cnt4", {16'd0, frame_cnt}, 32'd4);
    enable = 1'b1;
    wait_pix(0);
    check("pin_reen_adr", bus.adr, 32'h100);

    // asynchronous reset mid-burst
    wait_pix(12);
    #2 bus.rst = 1'b1;
    #1;
    check("pin_rst_cyc", {31'd0, bus.cyc}, 32'd0);
    check("pin_rst_stb", {31'd0, bus.stb}, 32'd0);
    @(negedge bus.clk);
    bus.rst = 1'b0;
    wait_pix(0);
    check("pin_rst_adr", bus.adr, 32'h100);
    check("pin_rst_cnt", {16'd0, frame_cnt}, 32'd0);
    wait_pix(40);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
